// File: rtl/hyp_func_unit_if.sv
// Request/response bus between the CPU HYP controller and hyp_func_unit.
interface hyp_func_unit_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 24
);
  logic             start;
  logic [IN_W-1:0]  a;
  logic [IN_W-1:0]  b;
  logic [OUT_W-1:0] y;
  logic             busy_o;

  modport master (output start, output a, output b, input y, input busy_o);
  modport slave  (input start, input a, input b, output y, output busy_o);
endinterface

// File: rtl/hyp_func_unit.sv
// Multi-cycle y = a^3 + b^2 responder built around one shared shift-add multiplier.
module hyp_func_unit #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 24
) (
  input  logic          clk,
  input  logic          rst,
  hyp_func_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(IN_W);

  generate
    if (OUT_W != 3 * IN_W) begin : g_width_check
      $error("hyp_func_unit: OUT_W must equal 3*IN_W");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, MUL_AA, MUL_AAA, MUL_BB, SUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [IN_W-1:0]  a_r, b_r;
  logic [OUT_W-1:0] acc, mcand, cube, y_r;
  logic [IN_W-1:0]  mplier;
  logic [CNT_W-1:0] cnt;
  logic             busy_r;
  logic             last_c;
  logic [OUT_W-1:0] prod_c;

  assign bus.y      = y_r;
  assign bus.busy_o = busy_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state plus one shift-add step of the shared multiplier
  always_comb begin
    state_nxt = state;
    last_c    = (cnt == CNT_W'(IN_W - 1));
    prod_c    = acc + (mplier[0] ? mcand : '0);
    case (state)
      IDLE:    if (bus.start) state_nxt = MUL_AA;
      MUL_AA:  if (last_c)    state_nxt = MUL_AAA;
      MUL_AAA: if (last_c)    state_nxt = MUL_BB;
      MUL_BB:  if (last_c)    state_nxt = SUM;
      SUM:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: on the last step of each product, reload the multiplier for the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      cube   <= '0;
      y_r    <= '0;
      busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            acc    <= '0;
            mcand  <= OUT_W'(bus.a);
            mplier <= bus.a;
            cnt    <= '0;
            busy_r <= 1'b1;
          end
        end
        MUL_AA, MUL_AAA, MUL_BB: begin
          if (!last_c) begin
            acc    <= prod_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            acc <= '0;
            if (state == MUL_AA) begin
              mcand  <= prod_c;
              mplier <= a_r;
            end else if (state == MUL_AAA) begin
              cube   <= prod_c;
              mcand  <= OUT_W'(b_r);
              mplier <= b_r;
            end else begin
              acc <= prod_c;
            end
          end
        end
        SUM: begin
          y_r    <= cube + acc;
          busy_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hyp_func_unit.sv
// Directed table-driven bench for hyp_func_unit plus hand-written multi-cycle sequences.
module tb_hyp_func_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  hyp_func_unit_if #(.IN_W(8), .OUT_W(24)) bus ();

  hyp_func_unit #(.IN_W(8), .OUT_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [23:0] y;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one request, optionally change operands on busy cycle chg_at, check length/result/no retrigger
  task automatic run_req(input logic [7:0] ra, input logic [7:0] rb, input logic [23:0] ey,
                         input int chg_at, input logic [7:0] na, input logic [7:0] nb,
                         input string tag);
    int w;
    int hi;
    bus.a     = ra;
    bus.b     = rb;
    bus.start = 1'b1;
    w = 0;
    do begin
      tick();
      w++;
    end while (!bus.busy_o && w < 5);
    chk({tag, " accept"}, 32'(bus.busy_o), 32'd1);
    hi = 0;
    while (bus.busy_o && hi < 100) begin
      hi++;
      if (hi == chg_at) begin
        bus.a = na;
        bus.b = nb;
      end
      tick();
    end
    chk({tag, " busy_len"}, 32'(hi), 32'd25);
    chk({tag, " y"}, 32'(bus.y), 32'(ey));
    tick();
    chk({tag, " no_retrigger"}, 32'(bus.busy_o), 32'd0);
    bus.start = 1'b0;
    tick();
    chk({tag, " idle_after"}, 32'(bus.busy_o), 32'd0);
    chk({tag, " y_hold"}, 32'(bus.y), 32'(ey));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    int lo;
    vecs[0] = '{8'd3,   8'd4,   24'd43};
    vecs[1] = '{8'd255, 8'd255, 24'hFE0100};
    vecs[2] = '{8'd0,   8'd0,   24'd0};
    vecs[3] = '{8'd2,   8'd0,   24'd8};
    vecs[4] = '{8'd1,   8'd1,   24'd2};
    vecs[5] = '{8'd10,  8'd10,  24'd1100};
    vecs[6] = '{8'd0,   8'd255, 24'd65025};
    vecs[7] = '{8'd255, 8'd0,   24'd16581375};
    vecs[8] = '{8'd16,  8'd3,   24'd4105};
    vecs[9] = '{8'd100, 8'd7,   24'd1000049};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset y", 32'(bus.y), 32'd0);
    chk("reset busy", 32'(bus.busy_o), 32'd0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle busy", 32'(bus.busy_o), 32'd0);
      chk("idle y", 32'(bus.y), 32'd0);
    end

    for (int i = 0; i < 10; i++)
      run_req(vecs[i].a, vecs[i].b, vecs[i].y, 0, 8'd0, 8'd0, $sformatf("vec%0d", i));

    // Operands changed while busy must be ignored
    run_req(8'd5, 8'd1, 24'd126, 3, 8'd7, 8'd9, "midflight");

    // Reset mid-operation aborts the request and clears y
    bus.a     = 8'd10;
    bus.b     = 8'd10;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("abort accept", 32'(bus.busy_o), 32'd1);
    repeat (11) tick();
    chk("abort still busy", 32'(bus.busy_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 32'(bus.busy_o), 32'd0);
    chk("abort y", 32'(bus.y), 32'd0);
    tick();
    chk("abort idle", 32'(bus.busy_o), 32'd0);
    run_req(8'd1, 8'd1, 24'd2, 0, 8'd0, 8'd0, "post_abort");

    // Back-to-back with start held high
    bus.a     = 8'd3;
    bus.b     = 8'd4;
    bus.start = 1'b1;
    tick();
    chk("b2b accept", 32'(bus.busy_o), 32'd1);
    for (int p = 0; p < 3; p++) begin
      hi = 0;
      while (bus.busy_o && hi < 100) begin
        hi++;
        tick();
      end
      chk($sformatf("b2b%0d busy_len", p), 32'(hi), 32'd25);
      chk($sformatf("b2b%0d y", p), 32'(bus.y), 32'd43);
      lo = 0;
      while (!bus.busy_o && lo < 10) begin
        lo++;
        if (p == 2 && lo == 2) bus.start = 1'b0;
        tick();
      end
      if (p < 2) chk($sformatf("b2b%0d gap", p), 32'(lo), 32'd2);
      else       chk("b2b stop", 32'(bus.busy_o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
